// File: rtl/bram_stream_writer.sv
// Purpose: stores a valid/ready word stream sequentially into BRAM from BASE_ADDR, NUM_WORDS per transfer.
// Latency: one cycle from accepted beat to BRAM write port; back-to-back beats give one write per cycle.
// Backpressure: in_ready is high for the whole WRITE state, so a source can stream without stalls.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start               begins a transfer; sampled in IDLE and DONE only
//   in_valid/in_ready   stream handshake; in_data is the accepted word
//   bram_en/bram_wen    registered BRAM enable / write enable
//   bram_addr/bram_din  registered BRAM address / write data
//   busy, done          WRITE-state and DONE-state levels
//   count               words accepted in the current/last transfer
//   checksum            running sum of accepted words modulo 2^W
//
// Optional feature: define BRAM_WRITER_CHECKSUM_EN to build the checksum adder;
// otherwise checksum is tied to zero.

module bram_stream_writer #(
    parameter int W          = 8,
    parameter int ADDR_WIDTH = 18,
    parameter int BASE_ADDR  = 0,
    parameter int NUM_WORDS  = 9216
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [W-1:0]          in_data,
    output logic                  in_ready,
    output logic                  bram_en,
    output logic                  bram_wen,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [W-1:0]          bram_din,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   count,
    output logic [W-1:0]          checksum
);

    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   LAST_CNT = (ADDR_WIDTH + 1)'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  beat;
    logic                  init;
    logic                  last_beat;

    // A beat is the final one of the transfer when it takes count to NUM_WORDS.
    assign last_beat = (count == LAST_CNT);
    assign beat      = in_valid && in_ready;
    // start only re-arms the block from IDLE or DONE; a running transfer ignores it.
    assign init      = start && ((state == S_IDLE) || (state == S_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // in_ready depends on state only, never on in_valid, so the handshake has no comb loop.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && last_beat) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = S_WRITE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // BRAM port is fully registered; address and data hold between writes so the
    // port only changes when a new beat is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= BASE;
            count     <= '0;
            bram_en   <= 1'b0;
            bram_wen  <= 1'b0;
            bram_addr <= BASE;
            bram_din  <= '0;
        end else begin
            bram_en  <= beat;
            bram_wen <= beat;
            if (init) begin
                ptr   <= BASE;
                count <= '0;
            end else if (beat) begin
                ptr       <= ptr + 1'b1;
                count     <= count + 1'b1;
                bram_addr <= ptr;
                bram_din  <= in_data;
            end
        end
    end

`ifdef BRAM_WRITER_CHECKSUM_EN
    logic [W-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else if (init) begin
            sum_q <= '0;
        end else if (beat) begin
            sum_q <= sum_q + in_data;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_bram_stream_writer.sv
// Purpose: directed self-checking bench for bram_stream_writer.
// Latency: inputs driven and outputs sampled on the falling edge, one rising edge per step.
// Backpressure: source gaps are modelled by toggling in_valid.

module tb_bram_stream_writer;

    localparam int W   = 8;
    localparam int AW  = 18;
    localparam int BA  = 27648;
    localparam int NW  = 4;
    localparam int BB  = 262143;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          bram_en;
    logic          bram_wen;
    logic [AW-1:0] bram_addr;
    logic [W-1:0]  bram_din;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
    logic [W-1:0]  checksum;

    logic          b_start = 1'b0;
    logic          b_valid = 1'b0;
    logic [W-1:0]  b_data = '0;
    logic          b_ready;
    logic          b_en;
    logic          b_wen;
    logic [AW-1:0] b_addr;
    logic [W-1:0]  b_din;
    logic          b_busy;
    logic          b_done;
    logic [AW:0]   b_count;
    logic [W-1:0]  b_checksum;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bram_stream_writer #(.W(W), .ADDR_WIDTH(AW), .BASE_ADDR(BA), .NUM_WORDS(NW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .bram_en(bram_en), .bram_wen(bram_wen), .bram_addr(bram_addr),
        .bram_din(bram_din), .busy(busy), .done(done), .count(count), .checksum(checksum)
    );

    bram_stream_writer #(.W(W), .ADDR_WIDTH(AW), .BASE_ADDR(BB), .NUM_WORDS(1)) dut_wrap (
        .clk(clk), .rst(rst), .start(b_start), .in_valid(b_valid), .in_data(b_data),
        .in_ready(b_ready), .bram_en(b_en), .bram_wen(b_wen), .bram_addr(b_addr),
        .bram_din(b_din), .busy(b_busy), .done(b_done), .count(b_count), .checksum(b_checksum)
    );

    task automatic step();
        @(negedge clk);
    endtask

    // Pulse start for one edge; afterwards the main DUT is in WRITE.
    task automatic kick();
        start = 1'b1;
        in_valid = 1'b0;
        step();
        start = 1'b0;
    endtask

    // Push one word through the main DUT, checking the write it produces.
    task automatic beat(input logic [W-1:0] d, input int idx);
        in_valid = 1'b1;
        in_data = d;
        step();
        in_valid = 1'b0;
        checks++;
        if (bram_wen !== 1'b1 || bram_en !== 1'b1 || bram_addr !== AW'(BA + idx) || bram_din !== d) begin
            errors++;
            $display("FAIL beat%0d: wen=%b en=%b addr=%0d din=%h, want wen=1 en=1 addr=%0d din=%h",
                     idx, bram_wen, bram_en, bram_addr, bram_din, BA + idx, d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (in_ready !== 1'b0 || bram_en !== 1'b0 || bram_wen !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: rdy=%b en=%b wen=%b busy=%b done=%b, want all 0",
                     in_ready, bram_en, bram_wen, busy, done);
        end
        checks++;
        if (bram_addr !== AW'(BA) || bram_din !== 8'h00 || count !== '0 || checksum !== 8'h00) begin
            errors++;
            $display("FAIL reset_dat: addr=%0d din=%h count=%0d csum=%h, want addr=%0d din=00 count=0 csum=00",
                     bram_addr, bram_din, count, checksum, BA);
        end
        rst = 1'b0;
        in_valid = 1'b1;   // ignored in IDLE
        in_data = 8'hEE;
        step();
        checks++;
        if (bram_wen !== 1'b0 || busy !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL idle_valid: wen=%b busy=%b count=%0d, want 0 0 0", bram_wen, busy, count);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stream();
        logic [W-1:0] d [4];
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
        kick();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || bram_wen !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL write_entry: rdy=%b busy=%b wen=%b count=%0d, want 1 1 0 0",
                     in_ready, busy, bram_wen, count);
        end
        for (int i = 0; i < 4; i++) begin
            beat(d[i], i);
        end
        checks++;
        if (done !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || count !== 19'd4) begin
            errors++;
            $display("FAIL stream_done: done=%b rdy=%b busy=%b count=%0d, want 1 0 0 4",
                     done, in_ready, busy, count);
        end
        in_valid = 1'b1;   // ignored in DONE
        in_data = 8'h55;
        step();
        in_valid = 1'b0;
        checks++;
        if (bram_wen !== 1'b0 || bram_en !== 1'b0 || done !== 1'b1 || count !== 19'd4 || bram_din !== 8'h44) begin
            errors++;
            $display("FAIL done_hold: wen=%b en=%b done=%b count=%0d din=%h, want 0 0 1 4 44",
                     bram_wen, bram_en, done, count, bram_din);
        end
    endtask

    task automatic test_gaps();
        logic       v [6];
        logic [AW-1:0] last_addr;
        int nb;
        int nw;
        v[0] = 1; v[1] = 0; v[2] = 1; v[3] = 0; v[4] = 1; v[5] = 1;
        nb = 0;
        nw = 0;
        last_addr = AW'(BA);
        kick();
        for (int k = 0; k < 6; k++) begin
            in_valid = v[k];
            in_data = W'(8'hA0 + k);
            step();
            checks++;
            if (v[k] && nb < 4) begin
                if (bram_wen !== 1'b1 || bram_addr !== AW'(BA + nb) || bram_din !== W'(8'hA0 + k)) begin
                    errors++;
                    $display("FAIL gap_write%0d: wen=%b addr=%0d din=%h, want 1 %0d %h",
                             k, bram_wen, bram_addr, bram_din, BA + nb, 8'hA0 + k);
                end
                last_addr = AW'(BA + nb);
                nb++;
            end else begin
                if (bram_wen !== 1'b0 || bram_addr !== last_addr) begin
                    errors++;
                    $display("FAIL gap_idle%0d: wen=%b addr=%0d, want 0 %0d", k, bram_wen, bram_addr, last_addr);
                end
            end
            if (bram_wen === 1'b1) nw++;
        end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        if (bram_wen === 1'b1) nw++;
        checks++;
        if (nw !== 4 || count !== 19'd4 || done !== 1'b1) begin
            errors++;
            $display("FAIL gap_total: writes=%0d count=%0d done=%b, want 4 4 1", nw, count, done);
        end
    endtask

    task automatic test_reset_mid();
        kick();
        beat(8'h01, 0);
        beat(8'h02, 1);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h77;
        step();
        checks++;
        if (in_ready !== 1'b0 || bram_wen !== 1'b0 || count !== '0 || busy !== 1'b0 || done !== 1'b0
            || bram_addr !== AW'(BA)) begin
            errors++;
            $display("FAIL reset_mid: rdy=%b wen=%b count=%0d busy=%b done=%b addr=%0d, want 0 0 0 0 0 %0d",
                     in_ready, bram_wen, count, busy, done, bram_addr, BA);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        kick();
        beat(8'h99, 0);
        beat(8'h98, 1);
        beat(8'h97, 2);
        beat(8'h96, 3);
        checks++;
        if (done !== 1'b1 || count !== 19'd4) begin
            errors++;
            $display("FAIL reset_restart: done=%b count=%0d, want 1 4", done, count);
        end
    endtask

    task automatic test_start_ignored();
        kick();
        beat(8'h31, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || count !== 19'd1 || bram_wen !== 1'b0) begin
            errors++;
            $display("FAIL start_in_write: busy=%b count=%0d wen=%b, want 1 1 0", busy, count, bram_wen);
        end
        beat(8'h32, 1);
        beat(8'h33, 2);
        beat(8'h34, 3);
        checks++;
        if (done !== 1'b1 || count !== 19'd4) begin
            errors++;
            $display("FAIL start_ign_done: done=%b count=%0d, want 1 4", done, count);
        end
        kick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || count !== '0) begin
            errors++;
            $display("FAIL restart_from_done: done=%b busy=%b count=%0d, want 0 1 0", done, busy, count);
        end
        beat(8'h41, 0);
        beat(8'h42, 1);
        beat(8'h43, 2);
        beat(8'h44, 3);
    endtask

    task automatic test_checksum();
        logic [W-1:0] exp_sum;
`ifdef BRAM_WRITER_CHECKSUM_EN
        exp_sum = 8'h12;
`else
        exp_sum = 8'h00;
`endif
        kick();
        checks++;
        if (checksum !== 8'h00) begin
            errors++;
            $display("FAIL csum_clear: got %h want 00", checksum);
        end
        beat(8'hFF, 0);
        beat(8'h02, 1);
        beat(8'h10, 2);
        beat(8'h01, 3);
        step();
        checks++;
        if (checksum !== exp_sum || done !== 1'b1) begin
            errors++;
            $display("FAIL csum_final: csum=%h done=%b, want %h 1", checksum, done, exp_sum);
        end
    endtask

    task automatic test_single_wrap();
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        b_valid = 1'b1;
        b_data = 8'h5A;
        step();
        checks++;
        if (b_wen !== 1'b1 || b_addr !== 18'h3FFFF || b_din !== 8'h5A || b_done !== 1'b1 || b_count !== 19'd1) begin
            errors++;
            $display("FAIL wrap_write: wen=%b addr=%h din=%h done=%b count=%0d, want 1 3ffff 5a 1 1",
                     b_wen, b_addr, b_din, b_done, b_count);
        end
        step();
        checks++;
        if (b_wen !== 1'b0 || b_ready !== 1'b0 || b_count !== 19'd1 || b_addr !== 18'h3FFFF) begin
            errors++;
            $display("FAIL wrap_nosecond: wen=%b rdy=%b count=%0d addr=%h, want 0 0 1 3ffff",
                     b_wen, b_ready, b_count, b_addr);
        end
        b_start = 1'b1;
        b_data = 8'h6B;
        step();
        b_start = 1'b0;
        step();
        b_valid = 1'b0;
        checks++;
        if (b_wen !== 1'b1 || b_addr !== 18'h3FFFF || b_din !== 8'h6B) begin
            errors++;
            $display("FAIL wrap_restart: wen=%b addr=%h din=%h, want 1 3ffff 6b", b_wen, b_addr, b_din);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_gaps();
        test_reset_mid();
        test_start_ignored();
        test_checksum();
        test_single_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
